// File: rtl/shift_arbiter_ctrl_if.sv
// Request, shifter and response signals of the shared-shifter arbiter.
// master = issue logic / shifter / consumer side, slave = the arbiter itself.
interface shift_arbiter_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [SH_W-1:0]   req0_b;
    logic [1:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [SH_W-1:0]   req1_b;
    logic [1:0]        req1_op;

    logic [DATA_W-1:0] sh_a;
    logic [SH_W-1:0]   sh_b;
    logic [1:0]        sh_op;
    logic [DATA_W-1:0] sh_out;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output sh_out, resp_ready,
        input  req0_ready, req1_ready, sh_a, sh_b, sh_op,
        input  resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  sh_out, resp_ready,
        output req0_ready, req1_ready, sh_a, sh_b, sh_op,
        output resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter sharing one combinational shifter between two requesters,
// with registered shifter operands and a tagged, backpressured response register.
module shift_arbiter_ctrl #(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    shift_arbiter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              pref_q, pref_d;
    logic [DATA_W-1:0] sh_a_q, sh_a_d;
    logic [SH_W-1:0]   sh_b_q, sh_b_d;
    logic [1:0]        sh_op_q, sh_op_d;
    logic              exec_id_q, exec_id_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic              grant_valid_s;
    logic              grant_id_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [SH_W-1:0]   sel_b_s;
    logic [1:0]        sel_op_s;

    // Grant selection: pref_q names the requester that wins a tie.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if ((state_q == ST_IDLE) && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = pref_q;
            end else if (bus.req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a_s  = bus.req0_a;
        sel_b_s  = bus.req0_b;
        sel_op_s = bus.req0_op;
        if (grant_id_s) begin
            sel_a_s  = bus.req1_a;
            sel_b_s  = bus.req1_b;
            sel_op_s = bus.req1_op;
        end else begin
            sel_a_s  = bus.req0_a;
            sel_b_s  = bus.req0_b;
            sel_op_s = bus.req0_op;
        end
    end

    // Next-state and datapath register updates; every register holds by default.
    always_comb begin
        state_d     = state_q;
        pref_d      = pref_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        sh_op_d     = sh_op_q;
        exec_id_d   = exec_id_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    pref_d = ~grant_id_s;
                    if (sel_b_s != {SH_W{1'b0}}) begin
                        sh_a_d    = sel_a_s;
                        sh_b_d    = sel_b_s;
                        sh_op_d   = sel_op_s;
                        exec_id_d = grant_id_s;
                        state_d   = ST_EXEC;
                    end else begin
                        // Zero shift is the identity for every op, so skip the shifter.
                        resp_data_d = sel_a_s;
                        resp_id_d   = grant_id_s;
                        state_d     = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_data_d = bus.sh_out;
                resp_id_d   = exec_id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pref_q      <= 1'b0;
            sh_a_q      <= {DATA_W{1'b0}};
            sh_b_q      <= {SH_W{1'b0}};
            sh_op_q     <= 2'b00;
            exec_id_q   <= 1'b0;
            resp_id_q   <= 1'b0;
            resp_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pref_q      <= pref_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            sh_op_q     <= sh_op_d;
            exec_id_q   <= exec_id_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.req0_ready = grant_valid_s & ~grant_id_s;
    assign bus.req1_ready = grant_valid_s &  grant_id_s;
    assign bus.sh_a       = sh_a_q;
    assign bus.sh_b       = sh_b_q;
    assign bus.sh_op      = sh_op_q;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;

endmodule
